// File: rtl/cam_capture_writer_if.sv
// ---------------------------------------------------------------------------
// cam_capture_writer_if
//   Bundles the OV7670 byte stream and the frame-buffer write port seen by
//   cam_capture_writer.
//
//   Camera side (driven by the sensor or the bench):
//     vsync    frame sync, high during the inter-frame gap
//     href     line valid, bytes are valid only while high
//     px_data  8-bit camera byte (RGB565, two bytes per pixel)
//   Buffer write side (driven by the writer):
//     addr_in  write address, AW bits
//     data_in  write data, RGB444, DW bits
//     regwrite write enable, one cycle per pixel
//
//   Modports:
//     master  the capture writer: consumes the camera stream, drives the
//             buffer write port
//     slave   the environment: camera source plus buffer write sink
// ---------------------------------------------------------------------------
interface cam_capture_writer_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;

    modport master (
        input  vsync,
        input  href,
        input  px_data,
        output addr_in,
        output data_in,
        output regwrite
    );

    modport slave (
        output vsync,
        output href,
        output px_data,
        input  addr_in,
        input  data_in,
        input  regwrite
    );
endinterface

// File: rtl/cam_capture_writer.sv
// ---------------------------------------------------------------------------
// cam_capture_writer
//   Write-side producer for the dual-port frame buffer. Samples the OV7670
//   RGB565 byte stream on the pixel clock, packs each pixel to RGB444 and
//   issues one buffer write per pixel at linear addresses 0..NPIX-1, where
//   NPIX = IMG_W*IMG_H. Address NPIX is the buffer's reserved black pixel and
//   is never written. Addressing restarts at every frame.
//
//   Ports:
//     clk_w       camera pixel clock (PCLK); also clocks the buffer write port
//     reset       synchronous, active-high
//     init        capture enable, level-sensitive
//     bus         cam_capture_writer_if.master: vsync/href/px_data in,
//                 addr_in/data_in/regwrite out (all outputs registered)
//     frame_done  one-cycle pulse at the end of each captured frame
//     overflow    sticky: the frame delivered more than NPIX pixels;
//                 cleared when the next frame starts (VS_HIGH)
//     busy        high in every state except IDLE
// ---------------------------------------------------------------------------
module cam_capture_writer #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic                  clk_w,
    input  logic                  reset,
    input  logic                  init,
    cam_capture_writer_if.master  bus,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  busy
);

    localparam logic [AW-1:0] NPIX = AW'(IMG_W * IMG_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VS,
        S_VS_HIGH,
        S_BYTE1,
        S_BYTE2,
        S_DONE
    } state_t;

    // RGB565 -> RGB444: the top four bits of each channel. The hi byte is
    // kept without bit 3 (the LSB of red), which never reaches the output.
    //   hi = RRRRRGGG, lo = GGGBBBBB
    //   R = hi[7:4], G = {hi[2:0], lo[7]}, B = lo[4:1]
    function automatic logic [11:0] pack_rgb444(
        input logic [6:0] hi_kept,   // {hi[7:4], hi[2:0]}
        input logic       lo_g,      // lo[7]
        input logic [3:0] lo_b       // lo[4:1]
    );
        return {hi_kept[6:3], hi_kept[2:0], lo_g, lo_b};
    endfunction

    // Pixel counter increment that never passes NPIX; the counter parks at
    // NPIX once the frame is full so later pixels can be recognised and dropped.
    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
        if (v >= NPIX) begin
            return NPIX;
        end
        return v + 1'b1;
    endfunction

    state_t        state_q, state_d;
    logic [6:0]    hi_q,    hi_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] data_q,  data_d;
    logic          wr_q,    wr_d;
    logic          ovf_q,   ovf_d;

    // ---- next-state / output logic -------------------------------------
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (init) begin
                    state_d = S_WAIT_VS;
                end
            end

            // Joining mid-frame is not allowed: only a vsync pulse opens a frame.
            S_WAIT_VS: begin
                if (bus.vsync) begin
                    state_d = S_VS_HIGH;
                end
            end

            S_VS_HIGH: begin
                if (!bus.vsync) begin
                    state_d = S_BYTE1;
                end
            end

            // vsync has priority over href in both byte states.
            S_BYTE1: begin
                if (bus.vsync) begin
                    state_d = S_DONE;
                end else if (bus.href) begin
                    hi_d    = {bus.px_data[7:4], bus.px_data[2:0]};
                    state_d = S_BYTE2;
                end
            end

            // href low here means the line carried an odd byte count: the
            // latched hi byte is abandoned and the counter does not move.
            S_BYTE2: begin
                if (bus.vsync) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BYTE1;
                    if (bus.href) begin
                        if (cnt_q == NPIX) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_d   = 1'b1;
                            addr_d = cnt_q;
                            data_d = DW'(pack_rgb444(hi_q, bus.px_data[7],
                                                     bus.px_data[4:1]));
                            cnt_d  = sat_inc(cnt_q);
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = init ? S_VS_HIGH : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new frame starts in VS_HIGH: the counter and overflow flag are
        // cleared on entry and held clear while vsync stays high.
        if (state_d == S_VS_HIGH) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    // ---- state and output registers ------------------------------------
    always_ff @(posedge clk_w) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.addr_in  = addr_q;
    assign bus.data_in  = data_q;
    assign bus.regwrite = wr_q;
    assign frame_done   = (state_q == S_DONE);
    assign overflow     = ovf_q;
    assign busy         = (state_q != S_IDLE);

endmodule
